// File: rtl/hub_port_if.sv
// Bundles the hub slot bus and the client request/done handshake of one hub_port.
// master is the port side; slave is the hub plus client side.
interface hub_port_if;
    logic        ena_bus;
    logic        bus_sel;
    logic [31:0] bus_q;
    logic        bus_ack;
    logic        bus_r;
    logic        bus_e;
    logic        bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        input  ena_bus, bus_sel, bus_q, bus_ack, req, wr, size, addr, wdata,
        output bus_r, bus_e, bus_w, bus_s, bus_a, bus_d, rdy, done, err, rdata
    );

    modport slave (
        output ena_bus, bus_sel, bus_q, bus_ack, req, wr, size, addr, wdata,
        input  bus_r, bus_e, bus_w, bus_s, bus_a, bus_d, rdy, done, err, rdata
    );
endinterface

// File: rtl/hub_port.sv
// Hub bus initiator occupying one time-sliced hub slot for a non-cog client.
// Define HUB_PORT_ALIGN_CHECK_EN to reject misaligned word/long requests with err.
module hub_port #(
    parameter int unsigned MAX_WINDOWS = 4
) (
    input logic        clk_cog_i,
    input logic        res_i,
    hub_port_if.master hub
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StIssue = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzWord = 2'b01;
    localparam logic [1:0] SzLong = 2'b10;
    localparam logic [1:0] SzBad  = 2'b11;

    localparam logic [3:0] WinMax = 4'(MAX_WINDOWS);

    logic [1:0]  state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  win_q, win_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic [15:0] addr_lat;
    logic [3:0]  win_inc;
    logic [31:0] rd_ext;
    logic [31:0] lane_d;
    logic        drive;

    // Phase enable is implicit in bus_sel timing; the port needs no separate phase tracking.
    logic unused_ena;
    assign unused_ena = hub.ena_bus;

`ifdef HUB_PORT_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((hub.size == SzWord) && hub.addr[0]) ||
                        ((hub.size == SzLong) && (hub.addr[1:0] != 2'b00));
    assign req_bad    = (hub.size == SzBad) || misaligned;
    assign addr_lat   = hub.addr;
`else
    assign req_bad  = (hub.size == SzBad);
    assign addr_lat = {hub.addr[15:2],
                       hub.addr[1] & (hub.size != SzLong),
                       hub.addr[0] & (hub.size != SzLong) & (hub.size != SzWord)};
`endif

    assign win_inc = win_q + 4'd1;

    always_comb begin
        case (size_q)
            SzByte:  rd_ext = {24'h0, hub.bus_q[8*addr_q[1:0] +: 8]};
            SzWord:  rd_ext = {16'h0, hub.bus_q[16*addr_q[1] +: 16]};
            default: rd_ext = hub.bus_q;
        endcase
    end

    always_comb begin
        case (size_q)
            SzByte:  lane_d = {4{wdata_q[7:0]}};
            SzWord:  lane_d = {2{wdata_q[15:0]}};
            default: lane_d = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        win_d   = win_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (hub.req) begin
                    wr_d    = hub.wr;
                    size_d  = hub.size;
                    addr_d  = addr_lat;
                    wdata_d = hub.wdata;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        win_d   = 4'd0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (hub.bus_sel) state_d = StIssue;
            end
            StIssue: begin
                if (hub.bus_sel) begin
                    if (hub.bus_ack) begin
                        err_d   = 1'b0;
                        state_d = StResp;
                        if (!wr_q) rdata_d = rd_ext;
                    end
                end else begin
                    // Slot passed without an ack: one owned window consumed.
                    win_d = win_inc;
                    if (win_inc == WinMax) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_cog_i) begin
        if (res_i) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 16'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            win_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            win_q   <= win_d;
            err_q   <= err_d;
        end
    end

    // Bus lines are OR-combined across slots, so everything is zero unless we own the slot.
    assign drive     = (state_q == StIssue) && hub.bus_sel;
    assign hub.bus_r = drive;
    assign hub.bus_e = 1'b0;
    assign hub.bus_w = drive & wr_q;
    assign hub.bus_s = drive ? size_q  : 2'b00;
    assign hub.bus_a = drive ? addr_q  : 16'h0;
    assign hub.bus_d = drive ? lane_d  : 32'h0;

    assign hub.rdy   = (state_q == StIdle);
    assign hub.done  = (state_q == StResp);
    assign hub.err   = (state_q == StResp) & err_q;
    assign hub.rdata = rdata_q;

endmodule

// File: tb/tb_hub_port.sv
// Directed bench for hub_port: free-running 8-slot hub model, scoreboard of expected completions.
module tb_hub_port;

    logic clk = 1'b0;
    logic res;
    logic [3:0] slot_q = 4'd0;
    logic ack_en;

    int checks = 0;
    int errors = 0;
    int win_cnt = 0;
    logic        cap_w;
    logic [1:0]  cap_s;
    logic [15:0] cap_a;
    logic [31:0] cap_d;
    logic [31:0] last_rdata;
    logic [32:0] sb_q[$];

    hub_port_if hub ();

    hub_port #(.MAX_WINDOWS(4)) dut (
        .clk_cog_i (clk),
        .res_i     (res),
        .hub       (hub)
    );

    always #5 clk = ~clk;
    always @(posedge clk) slot_q <= slot_q + 4'd1;

    // This port owns slot 0 of 8; each slot lasts two clocks.
    assign hub.bus_sel = (slot_q[3:1] == 3'd0);
    assign hub.ena_bus = slot_q[0];
    assign hub.bus_ack = hub.bus_r & ack_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (hub.bus_r === 1'b1) begin
            win_cnt++;
            cap_w = hub.bus_w;
            cap_s = hub.bus_s;
            cap_a = hub.bus_a;
            cap_d = hub.bus_d;
        end
        if (!hub.bus_sel)
            chk("bus_idle_zero",
                {11'h0, hub.bus_r, hub.bus_e, hub.bus_w, hub.bus_s, hub.bus_a, hub.bus_d},
                64'h0);
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] sz, input logic [15:0] a,
                                             input logic [31:0] q);
        logic [31:0] sh;
        if (sz == 2'b00) begin
            sh = q >> (a[1:0] * 8);
            return sh & 32'h0000_00FF;
        end
        if (sz == 2'b01) return a[1] ? {16'h0, q[31:16]} : {16'h0, q[15:0]};
        return q;
    endfunction

    task automatic txn(input string tag, input logic w, input logic [1:0] sz,
                       input logic [15:0] a, input logic [31:0] wd, input logic [31:0] q,
                       input logic ack, input logic exp_err, input int exp_win);
        int base;
        bit got;
        logic [32:0] exp_e;
        logic [31:0] exp_rd;
        for (int i = 0; i < 20 && !hub.rdy; i++) tick();
        chk({tag, "_rdy"}, hub.rdy, 1'b1);
        ack_en    = ack;
        hub.bus_q = q;
        hub.req   = 1'b1;
        hub.wr    = w;
        hub.size  = sz;
        hub.addr  = a;
        hub.wdata = wd;
        exp_rd = (exp_err || w) ? last_rdata : model_rd(sz, a, q);
        last_rdata = exp_rd;
        sb_q.push_back({exp_err, exp_rd});
        base = win_cnt;
        tick();
        hub.req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (hub.done) got = 1'b1;
            else tick();
        end
        chk({tag, "_done"}, hub.done, 1'b1);
        if (got) begin
            exp_e = sb_q.pop_front();
            chk({tag, "_err"}, hub.err, exp_e[32]);
            chk({tag, "_rdata"}, hub.rdata, exp_e[31:0]);
            chk({tag, "_rdy_resp"}, hub.rdy, 1'b0);
        end
        chk({tag, "_windows"}, win_cnt - base, exp_win);
        tick();
        chk({tag, "_b2b"}, {hub.rdy, hub.done}, 2'b10);
    endtask

    initial begin
        bit seen;
        res       = 1'b1;
        ack_en    = 1'b0;
        hub.req   = 1'b0;
        hub.wr    = 1'b0;
        hub.size  = 2'b00;
        hub.addr  = 16'h0;
        hub.wdata = 32'h0;
        hub.bus_q = 32'h0;
        last_rdata = 32'h0;
        repeat (3) tick();
        chk("reset_outs", {hub.rdy, hub.done, hub.err, hub.rdata}, {3'b100, 32'h0});
        chk("reset_bus", {hub.bus_r, hub.bus_e, hub.bus_w, hub.bus_s, hub.bus_a, hub.bus_d}, 0);
        res = 1'b0;
        tick();

        txn("long_rd", 1'b0, 2'b10, 16'h1234, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1);
        chk("long_rd_bus", {cap_w, cap_s, cap_a}, {1'b0, 2'b10, 16'h1234});

        txn("byte_wr", 1'b1, 2'b00, 16'h0102, 32'h0000_00A5, 32'h0, 1'b1, 1'b0, 1);
        chk("byte_wr_bus", {cap_w, cap_s, cap_a, cap_d}, {1'b1, 2'b00, 16'h0102, 32'hA5A5_A5A5});

        txn("word_rd", 1'b0, 2'b01, 16'h0012, 32'h0, 32'h8001_7FFE, 1'b1, 1'b0, 1);
        txn("byte_rd", 1'b0, 2'b00, 16'h0001, 32'h0, 32'h1122_3344, 1'b1, 1'b0, 1);

        txn("word_wr", 1'b1, 2'b01, 16'h0010, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 1);
        chk("word_wr_bus", {cap_w, cap_s, cap_d}, {1'b1, 2'b01, 32'h1234_1234});

        txn("no_ack", 1'b0, 2'b10, 16'h0040, 32'h0, 32'h5555_5555, 1'b0, 1'b1, 4);
        txn("bad_size", 1'b0, 2'b11, 16'h0020, 32'h0, 32'h7777_7777, 1'b1, 1'b1, 0);

`ifdef HUB_PORT_ALIGN_CHECK_EN
        txn("misalign", 1'b0, 2'b01, 16'h0003, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b1, 0);
`else
        txn("misalign", 1'b0, 2'b01, 16'h0003, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1);
        chk("misalign_addr", cap_a, 16'h0002);
`endif

        // Reset while the request is on the bus.
        ack_en    = 1'b0;
        hub.req   = 1'b1;
        hub.wr    = 1'b1;
        hub.size  = 2'b10;
        hub.addr  = 16'h0080;
        hub.wdata = 32'h0F0F_0F0F;
        tick();
        hub.req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (hub.bus_r) seen = 1'b1;
            else tick();
        end
        chk("rst_issue_seen", hub.bus_r, 1'b1);
        res = 1'b1;
        tick();
        chk("rst_mid_issue", {hub.bus_r, hub.bus_w, hub.rdy, hub.done}, 4'b0010);
        res = 1'b0;
        last_rdata = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hub.done) seen = 1'b1;
        end
        chk("rst_no_done", seen, 1'b0);

        txn("post_rst", 1'b0, 2'b10, 16'h0100, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 1);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
